// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle LEGv8 control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on the
// data-memory ready handshake with a timeout trap, and counts retirements.
// Optional feature: define MCTRL_CBNZ_EN to decode 10110101xxx as CBNZ;
// without it that opcode group is illegal.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_to_loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             instr_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_R, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B
    } cls_t;

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d;
    cls_t              dec_cls;
    cls_t              cur_cls;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;

    // Opcode classification; only consumed while in DECODE.
    always_comb begin
        dec_cls = C_ILL;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = C_R;
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10110100???: dec_cls = C_CBZ;
`ifdef MCTRL_CBNZ_EN
            11'b10110101???: dec_cls = C_CBNZ;
`endif
            11'b000101?????: dec_cls = C_B;
            default:         dec_cls = C_ILL;
        endcase
    end

    // Next-state, strobe decode, wait counter and retire bookkeeping.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_d     = '0;
        cause_d    = cause_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_to_loc = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;

        // The class register is loaded at the end of DECODE, so the register
        // read-2 select in DECODE itself has to use the live classification.
        cur_cls = (state_q == S_DECODE) ? dec_cls : cls_q;
        if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM)) begin
            reg_to_loc = (cur_cls == C_STUR) || (cur_cls == C_CBZ) || (cur_cls == C_CBNZ);
        end

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                    C_CBNZ: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = ~zero;
                        retire   = 1'b1;
                    end
                    C_B: begin
                        pc_src   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LDUR);
                mem_write = (cls_q == C_STUR);
                if (mem_ready) begin
                    // A completing access wins over a timeout in the same cycle.
                    if (cls_q == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
                retire     = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // run is looked at only when an instruction retires.
        if (retire) begin
            instr_done = 1'b1;
            retired_d  = retired_q + 1'b1;
            state_d    = run ? S_FETCH : S_IDLE;
        end
    end

    // State, class, wait counter, trap cause and retire counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ILL;
            wait_q    <= '0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table of instructions with hand-derived
// cycle counts and trap causes, random instruction streams against a
// per-instruction phase model, and hand sequences for reset mid-MEM and
// trap stickiness. Honours MCTRL_CBNZ_EN if it is defined for the build.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam int K_ILL = 0, K_R = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_CBNZ = 5, K_B = 6;
    localparam int M_IDLE = 0, M_RUN = 1, M_TRAP = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic [10:0]   opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_src, ir_write, reg_to_loc, alu_src;
    logic [1:0]    alu_op;
    logic          mem_read, mem_write, mem_to_reg, reg_write, instr_done, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .reg_to_loc (reg_to_loc),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       reg_to_loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  rdy;
        logic  zr;
        logic  rn;
    } cyc_t;

    typedef struct {
        string       nm;
        logic [10:0] op;
        logic        z;
        int          w;
        logic        rn;
        int          cyc;
        logic [1:0]  cause;
    } vec_t;

    outs_t act;
    assign act = {pc_write, pc_src, ir_write, reg_to_loc, alu_src, alu_op, mem_read,
                  mem_write, mem_to_reg, reg_write, instr_done, trap, trap_cause};

    int         total = 0;
    int         bad = 0;
    int         model_cnt = 0;
    int         cnt_before = 0;
    int         mstate = M_IDLE;
    logic [1:0] model_cause = 2'b00;
    logic [1:0] obs_cause = 2'b00;
    cyc_t       exp_q[$];
    vec_t       tbl[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    // Instruction class straight from the opcode encodings.
    function automatic int kind_of(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (hi8 == 8'b10110100) return K_CBZ;
`ifdef MCTRL_CBNZ_EN
        if (hi8 == 8'b10110101) return K_CBNZ;
`endif
        if (hi6 == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    task automatic push(input outs_t ov, input logic rdy, input logic zr, input logic rn);
        cyc_t c;
        c.o = ov;
        c.rdy = rdy;
        c.zr = zr;
        c.rn = rn;
        exp_q.push_back(c);
    endtask

    task automatic retire_model(input logic rn);
        model_cnt = (model_cnt + 1) % (1 << CW);
        mstate = rn ? M_RUN : M_IDLE;
    endtask

    // Expected per-cycle outputs (and inputs to apply) for one instruction
    // that starts in FETCH: w = number of not-ready MEM cycles.
    task automatic build(input logic [10:0] op, input logic z, input int w, input logic rn);
        int    k;
        logic  cb, uses_rt, rdy;
        outs_t o;
        k = kind_of(op);
        cb = (k == K_CBZ) || (k == K_CBNZ);
        uses_rt = cb || (k == K_ST);
        exp_q.delete();
        cnt_before = model_cnt;
        o = '0; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, rb(), rb(), rb());
        o = '0; o.reg_to_loc = uses_rt;
        push(o, rb(), rb(), rb());
        if (k == K_ILL) begin
            o = '0; o.trap = 1'b1; o.trap_cause = 2'b01;
            push(o, rb(), rb(), rb());
            mstate = M_TRAP;
            model_cause = 2'b01;
            return;
        end
        o = '0;
        o.reg_to_loc = uses_rt;
        o.alu_src = (k == K_LD) || (k == K_ST);
        o.alu_op = cb ? 2'b01 : ((k == K_R) ? 2'b10 : 2'b00);
        if (cb || k == K_B) begin
            o.pc_src = 1'b1;
            o.pc_write = (k == K_B) ? 1'b1 : ((k == K_CBZ) ? z : ~z);
            o.instr_done = 1'b1;
            push(o, rb(), z, rn);
            retire_model(rn);
            return;
        end
        push(o, rb(), z, rb());
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < TO; i++) begin
                rdy = (i >= w);
                o = '0;
                o.mem_read = (k == K_LD);
                o.mem_write = (k == K_ST);
                o.reg_to_loc = uses_rt;
                o.instr_done = rdy && (k == K_ST);
                push(o, rdy, rb(), (rdy && k == K_ST) ? rn : rb());
                if (rdy) begin
                    if (k == K_ST) begin
                        retire_model(rn);
                        return;
                    end
                    break;
                end
                if (i + 1 == TO) begin
                    o = '0; o.trap = 1'b1; o.trap_cause = 2'b10;
                    push(o, rb(), rb(), rb());
                    mstate = M_TRAP;
                    model_cause = 2'b10;
                    return;
                end
            end
        end
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = (k == K_LD); o.instr_done = 1'b1;
        push(o, rb(), rb(), rn);
        retire_model(rn);
    endtask

    // Apply up to n queued cycles; cyc counts cycles up to retirement, or
    // up to (not including) the first trap cycle.
    task automatic exec_q(input string tag, input int n, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            mem_ready = exp_q[i].rdy;
            zero = exp_q[i].zr;
            run = exp_q[i].rn;
            #1;
            if (i == 0) chk({tag, " retired"}, 32'(retired), 32'(cnt_before));
            if (!seen) begin
                if (trap) seen = 1'b1;
                else begin
                    cyc++;
                    if (instr_done) seen = 1'b1;
                end
            end
            chk($sformatf("%s c%0d", tag, i), 32'(act), 32'(exp_q[i].o));
            obs_cause = trap_cause;
            @(negedge clk);
        end
    endtask

    task automatic step(input string nm, input outs_t want, input logic rn);
        run = rn;
        mem_ready = rb();
        zero = rb();
        #1;
        chk(nm, 32'(act), 32'(want));
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle must clear outputs before the next edge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, " rst outs"}, 32'(act), 32'(0));
        chk({tag, " rst retired"}, 32'(retired), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        model_cnt = 0;
        mstate = M_IDLE;
    endtask

    task automatic run_one(input string tag, input logic [10:0] op, input logic z,
                           input int w, input logic rn, output int cyc);
        outs_t t;
        if (mstate == M_IDLE) begin
            step({tag, " idle0"}, '0, 1'b0);
            step({tag, " idle1"}, '0, 1'b1);
        end
        opcode = op;
        build(op, z, w, rn);
        exec_q(tag, exp_q.size(), cyc);
        if (mstate == M_TRAP) begin
            t = '0;
            t.trap = 1'b1;
            t.trap_cause = model_cause;
            for (int j = 0; j < 3; j++) step($sformatf("%s hold%0d", tag, j), t, rb());
            do_reset(tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          r;
        logic [10:0] op;
        logic [10:0] rops [4];
        rops[0] = 11'b10001011000;
        rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000;
        rops[3] = 11'b10101010000;

        tbl.push_back('{"add",      11'b10001011000, 1'b0, 0, 1'b1, 4, 2'b00});
        tbl.push_back('{"ldur_w3",  11'b11111000010, 1'b0, 3, 1'b1, 8, 2'b00});
        tbl.push_back('{"cbz_t",    11'b10110100101, 1'b1, 0, 1'b1, 3, 2'b00});
        tbl.push_back('{"cbz_nt",   11'b10110100000, 1'b0, 0, 1'b1, 3, 2'b00});
        tbl.push_back('{"stur_w2",  11'b11111000000, 1'b0, 2, 1'b1, 6, 2'b00});
        tbl.push_back('{"sub_stop", 11'b11001011000, 1'b0, 0, 1'b0, 4, 2'b00});
        tbl.push_back('{"and",      11'b10001010000, 1'b1, 0, 1'b1, 4, 2'b00});
        tbl.push_back('{"orr",      11'b10101010000, 1'b0, 0, 1'b1, 4, 2'b00});
        tbl.push_back('{"b",        11'b00010111111, 1'b0, 0, 1'b1, 3, 2'b00});
        tbl.push_back('{"ldur_w0",  11'b11111000010, 1'b0, 0, 1'b1, 5, 2'b00});
        tbl.push_back('{"stur_w3",  11'b11111000000, 1'b0, 3, 1'b1, 7, 2'b00});
`ifdef MCTRL_CBNZ_EN
        tbl.push_back('{"cbnz_z0",  11'b10110101000, 1'b0, 0, 1'b1, 3, 2'b00});
        tbl.push_back('{"cbnz_z1",  11'b10110101111, 1'b1, 0, 1'b1, 3, 2'b00});
`else
        tbl.push_back('{"cbnz_z0",  11'b10110101000, 1'b0, 0, 1'b1, 2, 2'b01});
        tbl.push_back('{"cbnz_z1",  11'b10110101111, 1'b1, 0, 1'b1, 2, 2'b01});
`endif
        tbl.push_back('{"illegal",  11'b11111111111, 1'b0, 0, 1'b1, 2, 2'b01});
        tbl.push_back('{"ldur_to",  11'b11111000010, 1'b0, 4, 1'b1, 7, 2'b10});
        tbl.push_back('{"stur_to",  11'b11111000000, 1'b0, 9, 1'b1, 7, 2'b10});
        tbl.push_back('{"add_near", 11'b10001011001, 1'b0, 0, 1'b1, 2, 2'b01});
        tbl.push_back('{"ldur_near",11'b11111000011, 1'b0, 0, 1'b1, 2, 2'b01});

        @(negedge clk);
        do_reset("init");

        foreach (tbl[i]) begin
            run_one(tbl[i].nm, tbl[i].op, tbl[i].z, tbl[i].w, tbl[i].rn, cyc);
            chk({tbl[i].nm, " cycles"}, 32'(cyc), 32'(tbl[i].cyc));
            chk({tbl[i].nm, " cause"}, 32'(obs_cause), 32'(tbl[i].cause));
        end

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 4)       op = rops[r];
            else if (r < 6)  op = 11'b11111000010;
            else if (r < 8)  op = 11'b11111000000;
            else if (r < 10) op = {8'b10110100, 3'($urandom)};
            else if (r < 11) op = {8'b10110101, 3'($urandom)};
            else if (r < 13) op = {6'b000101, 5'($urandom)};
            else             op = 11'($urandom);
            run_one($sformatf("rnd%0d", n), op, rb(), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 4) != 0), cyc);
        end

        // Reset while an LDUR is stalled in MEM.
        if (mstate == M_TRAP) do_reset("pre");
        do_reset("mid_pre");
        run_one("mid_add", 11'b10001011000, 1'b0, 0, 1'b1, cyc);
        opcode = 11'b11111000010;
        build(11'b11111000010, 1'b0, 10, 1'b1);
        exec_q("mid_ldur", 5, cyc);
        mem_ready = 1'b0;
        do_reset("mid_mem");
        run_one("post_add", 11'b10001011000, 1'b0, 0, 1'b0, cyc);
        #1;
        chk("final retired", 32'(retired), 32'(model_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
